// File: rtl/vr_pkg.sv
// ----------------------------------------------------------------------------
// vr_pkg
// Shared definitions for the VR tooth decoder: default wheel/filter/counter
// sizes and the wheel-tracking state encoding.
// ----------------------------------------------------------------------------
package vr_pkg;

    // 60-2 wheel: 58 physical edges per revolution, gap edge included.
    localparam int DEF_TEETH  = 58;
    localparam int DEF_FILT_W = 8;
    localparam int DEF_PER_W  = 24;

    // Wheel position tracking.
    //   ST_IDLE   : no valid tooth period yet
    //   ST_HUNT   : periods valid, waiting for a gap
    //   ST_VERIFY : one gap seen, counting teeth up to the next gap
    //   ST_SYNC   : gaps arrive exactly one revolution apart
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_SYNC   = 2'd3
    } vr_state_t;

endpackage

// File: rtl/vr_filt.sv
// ----------------------------------------------------------------------------
// vr_filt
// Input conditioning for the raw VR comparator: a 2-flop synchroniser followed
// by a glitch filter. The filtered level only follows the synchronised input
// once the input has disagreed with it for filt_len+1 consecutive clocks.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-low reset
//   vr_in     raw asynchronous comparator output
//   filt_len  filter length N (quasi-static)
//   vr_out    filtered level
// ----------------------------------------------------------------------------
module vr_filt
    import vr_pkg::*;
#(
    parameter int FILT_W = DEF_FILT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vr_in,
    input  logic [FILT_W-1:0] filt_len,
    output logic              vr_out
);

    logic              s1;
    logic              s2;
    logic [FILT_W-1:0] cnt;

    // NOTE: every register here uses non-blocking assignment so s1->s2->vr_out
    // behave as a true shift chain regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            vr_out <= 1'b0;
        end else begin
            s1 <= vr_in;
            s2 <= s1;
            if (s2 == vr_out) begin
                // Any agreement restarts the qualification window.
                cnt <= '0;
            end else if (cnt == filt_len) begin
                vr_out <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + FILT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vr_tooth_decoder.sv
// ----------------------------------------------------------------------------
// vr_tooth_decoder
// Upstream stage of the crank-angle generator. Filters the VR signal, turns
// the selected filtered transition into a tooth-edge strobe, measures the
// clock count between tooth edges, detects the missing-tooth gap and tracks
// the tooth index against a TEETH-edge wheel.
//
// Ports
//   clk         system clock, all logic on rising edge
//   rst         synchronous, active-low reset
//   vr_in       raw asynchronous VR comparator output
//   filt_len    glitch filter length N (quasi-static)
//   edge_sel    0: falling filtered edge is the tooth edge, 1: rising
//   vr_out      filtered level
//   edge_stb    one-cycle tooth-edge strobe
//   period      clocks between the last two tooth edges
//   period_vld  with edge_stb, when period spans two real edges
//   gap_stb     with edge_stb, when this edge ends the missing-tooth gap
//   tooth_cnt   tooth index, gap edge = 0 (meaningful when sync)
//   sync        wheel position locked
//   err_stb     with edge_stb, tooth-count / gap disagreement
//   stall       period counter saturated (engine stopped)
// ----------------------------------------------------------------------------
module vr_tooth_decoder
    import vr_pkg::*;
#(
    parameter int TEETH  = DEF_TEETH,
    parameter int FILT_W = DEF_FILT_W,
    parameter int PER_W  = DEF_PER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vr_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              edge_sel,
    output logic              vr_out,
    output logic              edge_stb,
    output logic [PER_W-1:0]  period,
    output logic              period_vld,
    output logic              gap_stb,
    output logic [5:0]        tooth_cnt,
    output logic              sync,
    output logic              err_stb,
    output logic              stall
);

    localparam logic [PER_W-1:0] PER_MAX    = '1;
    localparam logic [5:0]       LAST_TOOTH = 6'(TEETH - 1);

    logic             vr_d;        // filtered level one clock ago
    logic             tooth_edge;  // selected filtered transition, this cycle
    logic             is_gap;
    logic [PER_W-1:0] per_cnt;
    logic             prev_vld;    // at least one edge since reset/stall
    logic             pp_vld;      // period register holds a real period
    logic [5:0]       tooth_inc;
    vr_state_t        state;

    vr_filt #(
        .FILT_W (FILT_W)
    ) u_filt (
        .clk      (clk),
        .rst      (rst),
        .vr_in    (vr_in),
        .filt_len (filt_len),
        .vr_out   (vr_out)
    );

    assign tooth_edge = edge_sel ? (vr_out & ~vr_d) : (~vr_out & vr_d);

    // The period register still holds the previous period while the edge is
    // being evaluated, so it doubles as prev_period. The doubled value is
    // compared one bit wider so it cannot overflow.
    assign is_gap = tooth_edge & pp_vld & ({1'b0, per_cnt} > {period, 1'b0});

    // Free-running tooth index wraps at the end of the wheel.
    assign tooth_inc = (tooth_cnt == LAST_TOOTH) ? 6'd0 : tooth_cnt + 6'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vr_d       <= 1'b0;
            edge_stb   <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            gap_stb    <= 1'b0;
            err_stb    <= 1'b0;
            tooth_cnt  <= '0;
            sync       <= 1'b0;
            stall      <= 1'b0;
            per_cnt    <= '0;
            prev_vld   <= 1'b0;
            pp_vld     <= 1'b0;
            state      <= ST_IDLE;
        end else begin
            vr_d       <= vr_out;
            edge_stb   <= tooth_edge;
            period_vld <= tooth_edge & prev_vld;
            gap_stb    <= is_gap;
            err_stb    <= 1'b0;

            if (tooth_edge) begin
                // An edge always wins over saturation in the same cycle.
                period   <= per_cnt;
                per_cnt  <= PER_W'(1);
                prev_vld <= 1'b1;
                pp_vld   <= prev_vld;
                stall    <= 1'b0;

                case (state)
                    ST_IDLE: begin
                        tooth_cnt <= tooth_inc;
                        if (prev_vld) begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_HUNT: begin
                        if (is_gap) begin
                            state     <= ST_VERIFY;
                            tooth_cnt <= '0;
                        end else begin
                            tooth_cnt <= tooth_inc;
                        end
                    end
                    ST_VERIFY, ST_SYNC: begin
                        if (is_gap) begin
                            // Every gap restarts the count; only a gap landing
                            // on the last tooth confirms the wheel.
                            tooth_cnt <= '0;
                            if (tooth_cnt == LAST_TOOTH) begin
                                state <= ST_SYNC;
                                sync  <= 1'b1;
                            end else begin
                                state   <= ST_VERIFY;
                                sync    <= 1'b0;
                                err_stb <= 1'b1;
                            end
                        end else if (tooth_cnt == LAST_TOOTH) begin
                            // Expected a gap here but saw a normal tooth.
                            state     <= ST_HUNT;
                            sync      <= 1'b0;
                            err_stb   <= 1'b1;
                            tooth_cnt <= '0;
                        end else begin
                            tooth_cnt <= tooth_inc;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        sync  <= 1'b0;
                    end
                endcase
            end else if (per_cnt == PER_MAX) begin
                // Engine stopped: drop all history that depends on timing.
                stall    <= 1'b1;
                prev_vld <= 1'b0;
                pp_vld   <= 1'b0;
                state    <= ST_HUNT;
                sync     <= 1'b0;
            end else begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vr_tooth_decoder.sv
// ----------------------------------------------------------------------------
// tb_vr_tooth_decoder
// Directed stimulus for the VR tooth decoder. Each generated tooth edge pushes
// its hand-derived expected response into a queue; an independent monitor
// pops and compares whenever the DUT raises edge_stb.
// ----------------------------------------------------------------------------
module tb_vr_tooth_decoder;
    import vr_pkg::*;

    localparam int PER_W = 12;
    localparam int LOW   = 16;   // clocks vr_in stays low after each fall

    typedef struct {
        bit               chk_period;
        logic [PER_W-1:0] period;
        bit               vld;
        bit               gap;
        logic [5:0]       tooth;
        bit               sync;
        bit               err;
        vr_state_t        state;
    } exp_t;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             vr_in    = 1'b0;
    logic [7:0]       filt_len = 8'd3;
    logic             edge_sel = 1'b0;
    logic             vr_out;
    logic             edge_stb;
    logic [PER_W-1:0] period;
    logic             period_vld;
    logic             gap_stb;
    logic [5:0]       tooth_cnt;
    logic             sync;
    logic             err_stb;
    logic             stall;

    exp_t exp_q[$];
    int   checks        = 0;
    int   failures      = 0;
    int   cyc           = 0;
    int   last_edge_cyc = 0;
    int   n_edges       = 0;

    vr_tooth_decoder #(
        .TEETH  (58),
        .FILT_W (8),
        .PER_W  (PER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vr_in      (vr_in),
        .filt_len   (filt_len),
        .edge_sel   (edge_sel),
        .vr_out     (vr_out),
        .edge_stb   (edge_stb),
        .period     (period),
        .period_vld (period_vld),
        .gap_stb    (gap_stb),
        .tooth_cnt  (tooth_cnt),
        .sync       (sync),
        .err_stb    (err_stb),
        .stall      (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(bit cp, int per, bit vld, bit gap, int tooth,
                                bit sy, bit err, vr_state_t st);
        exp_t e;
        e.chk_period = cp;
        e.period     = PER_W'(per);
        e.vld        = vld;
        e.gap        = gap;
        e.tooth      = 6'(tooth);
        e.sync       = sy;
        e.err        = err;
        e.state      = st;
        return e;
    endfunction

    // Monitor: compares on every edge strobe, and checks that no edge-only
    // strobe appears on its own.
    always @(negedge clk) begin
        exp_t e;
        if (rst && edge_stb) begin
            last_edge_cyc = cyc;
            n_edges++;
            check($sformatf("e%0d_polarity", n_edges), 32'(vr_out), 32'(edge_sel));
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL e%0d_unexpected_edge: got edge_stb=1 expected no edge", n_edges);
            end else begin
                e = exp_q.pop_front();
                if (e.chk_period)
                    check($sformatf("e%0d_period", n_edges), 32'(period), 32'(e.period));
                check($sformatf("e%0d_period_vld", n_edges), 32'(period_vld), 32'(e.vld));
                check($sformatf("e%0d_gap_stb", n_edges), 32'(gap_stb), 32'(e.gap));
                check($sformatf("e%0d_tooth_cnt", n_edges), 32'(tooth_cnt), 32'(e.tooth));
                check($sformatf("e%0d_sync", n_edges), 32'(sync), 32'(e.sync));
                check($sformatf("e%0d_err_stb", n_edges), 32'(err_stb), 32'(e.err));
                check($sformatf("e%0d_stall", n_edges), 32'(stall), 32'd0);
                check($sformatf("e%0d_state", n_edges), 32'(dut.state), 32'(e.state));
            end
        end else begin
            check("stray_strobe", {29'd0, period_vld, gap_stb, err_stb}, 32'd0);
        end
    end

    // One falling edge, p clocks after the previous fall.
    task automatic send_edge(input int p, input exp_t e);
        vr_in = 1'b1;
        repeat (p - LOW) @(posedge clk);
        #1;
        exp_q.push_back(e);
        vr_in = 1'b0;
        repeat (LOW) @(posedge clk);
        #1;
    endtask

    // One rising edge; the next rise follows p clocks later.
    task automatic rise_edge(input int p, input exp_t e);
        exp_q.push_back(e);
        vr_in = 1'b1;
        repeat (p - LOW) @(posedge clk);
        #1;
        vr_in = 1'b0;
        repeat (LOW) @(posedge clk);
        #1;
    endtask

    task automatic teeth(input int first, input int last, input int p, input vr_state_t st);
        for (int i = first; i <= last; i++)
            send_edge(p, mk(1, p, 1, 0, i, st == ST_SYNC, 0, st));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_vr_out"}, 32'(vr_out), 32'd0);
        check({tag, "_edge_stb"}, 32'(edge_stb), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_period_vld"}, 32'(period_vld), 32'd0);
        check({tag, "_gap_stb"}, 32'(gap_stb), 32'd0);
        check({tag, "_tooth_cnt"}, 32'(tooth_cnt), 32'd0);
        check({tag, "_sync"}, 32'(sync), 32'd0);
        check({tag, "_err_stb"}, 32'(err_stb), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
    endtask

    initial begin
        int waited;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        rst = 1'b1;

        // Filter, N=3: a 3-clock pulse must be rejected.
        @(posedge clk);
        #1;
        vr_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vr_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("glitch_vr_out", 32'(vr_out), 32'd0);
        end

        // Held step: vr_out rises exactly 2+N+1 = 6 clocks later.
        @(posedge clk);
        #1;
        vr_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("step_vr_out_at5", 32'(vr_out), 32'd0);
        @(posedge clk);
        #1;
        check("step_vr_out_at6", 32'(vr_out), 32'd1);

        // 60-2 wheel entered at tooth 45, tooth 256 clk, gap 768 clk.
        send_edge(256, mk(0, 0, 0, 0, 1, 0, 0, ST_IDLE));
        for (int i = 2; i <= 13; i++)
            send_edge(256, mk(1, 256, 1, 0, i, 0, 0, ST_HUNT));
        send_edge(768, mk(1, 768, 1, 1, 0, 0, 0, ST_VERIFY));
        teeth(1, 57, 256, ST_VERIFY);
        send_edge(768, mk(1, 768, 1, 1, 0, 1, 0, ST_SYNC));
        teeth(1, 57, 256, ST_SYNC);
        send_edge(768, mk(1, 768, 1, 1, 0, 1, 0, ST_SYNC));

        // Synced, faster wheel (64/192): one tooth edge dropped. The 128-clk
        // interval is exactly twice the previous one and is not a gap.
        teeth(1, 9, 64, ST_SYNC);
        send_edge(128, mk(1, 128, 1, 0, 10, 1, 0, ST_SYNC));
        teeth(11, 56, 64, ST_SYNC);
        send_edge(192, mk(1, 192, 1, 1, 0, 0, 1, ST_VERIFY));
        teeth(1, 57, 64, ST_VERIFY);
        send_edge(192, mk(1, 192, 1, 1, 0, 1, 0, ST_SYNC));

        // Synced, an extra tooth where the gap belongs: error back to HUNT.
        teeth(1, 57, 64, ST_SYNC);
        send_edge(64, mk(1, 64, 1, 0, 0, 0, 1, ST_HUNT));
        send_edge(192, mk(1, 192, 1, 1, 0, 0, 0, ST_VERIFY));
        teeth(1, 57, 64, ST_VERIFY);
        send_edge(192, mk(1, 192, 1, 1, 0, 1, 0, ST_SYNC));

        // Mid-revolution reset while synced.
        teeth(1, 20, 64, ST_SYNC);
        rst = 1'b0;
        @(posedge clk);
        #1;
        reset_checks("midrst");
        rst = 1'b1;

        // Relock needs two gaps.
        send_edge(64, mk(0, 0, 0, 0, 1, 0, 0, ST_IDLE));
        send_edge(64, mk(1, 64, 1, 0, 2, 0, 0, ST_HUNT));
        send_edge(64, mk(1, 64, 1, 0, 3, 0, 0, ST_HUNT));
        send_edge(192, mk(1, 192, 1, 1, 0, 0, 0, ST_VERIFY));
        teeth(1, 57, 64, ST_VERIFY);
        send_edge(192, mk(1, 192, 1, 1, 0, 1, 0, ST_SYNC));

        // Synced, wheel stops: stall exactly 4095 clocks after the last edge.
        waited = 0;
        while (!stall && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("stall_set", 32'(stall), 32'd1);
        check("stall_latency", 32'(cyc - last_edge_cyc), 32'd4095);
        check("stall_sync", 32'(sync), 32'd0);
        check("stall_state", 32'(dut.state), 32'(ST_HUNT));
        @(posedge clk);
        #1;

        // Resume: first edge captures the saturated count but is not valid.
        send_edge(256, mk(1, 4095, 0, 0, 1, 0, 0, ST_HUNT));
        send_edge(256, mk(1, 256, 1, 0, 2, 0, 0, ST_HUNT));

        // Rising edges as tooth edges, same spacing.
        edge_sel = 1'b1;
        repeat (256 - LOW) @(posedge clk);
        #1;
        rise_edge(256, mk(1, 256, 1, 0, 3, 0, 0, ST_HUNT));
        rise_edge(768, mk(1, 256, 1, 0, 4, 0, 0, ST_HUNT));
        rise_edge(256, mk(1, 768, 1, 1, 0, 0, 0, ST_VERIFY));
        rise_edge(256, mk(1, 256, 1, 0, 1, 0, 0, ST_VERIFY));

        repeat (20) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit reached");
    end

endmodule
